// File: rtl/derive_real_size_multitap.sv
// Converts extended block sizes (size + filter margin) back to real sizes, arbitrating
// round-robin across FLUX input fifos into one tagged, registered output word.
module derive_real_size_multitap #(
    parameter int FLUX        = 2,
    parameter int DATA_WIDTH  = 7,
    parameter int LUMA_DIFF   = 7,
    parameter int CHROMA_DIFF = 3,
    localparam int TAG_WIDTH  = (FLUX == 1) ? 1 : $clog2(FLUX)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [FLUX-1:0]                 chroma_mode_i,
    output logic [FLUX-1:0]                 underflow_o,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] ext_size_dout_i,
    input  logic [FLUX-1:0]                 ext_size_empty_i,
    output logic [FLUX-1:0]                 ext_size_read_o,
    input  logic                            real_size_full_i,
    output logic                            real_size_write_o,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0] real_size_din_o
);

    localparam logic [DATA_WIDTH-1:0] LUMA_D   = DATA_WIDTH'(LUMA_DIFF);
    localparam logic [DATA_WIDTH-1:0] CHROMA_D = DATA_WIDTH'(CHROMA_DIFF);
    localparam logic [TAG_WIDTH-1:0]  LAST_IDX = TAG_WIDTH'(FLUX - 1);

    logic                  out_valid_q, out_valid_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
    logic [DATA_WIDTH-1:0] out_size_q, out_size_d;
    logic [TAG_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [FLUX-1:0]       underflow_q, underflow_d;

    logic                  accept;
    logic                  grant_vld;
    logic [TAG_WIDTH-1:0]  grant;
    logic [TAG_WIDTH-1:0]  scan_idx;
    logic [DATA_WIDTH-1:0] ext_size;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] real_size;
    logic                  short_size;
    logic [TAG_WIDTH-1:0]  unused_dout_hi;

    assign ext_size       = ext_size_dout_i[DATA_WIDTH-1:0];
    assign unused_dout_hi = ext_size_dout_i[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH];

    // Register is free, or its word leaves this cycle.
    assign accept = ~out_valid_q | ~real_size_full_i;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        scan_idx  = '0;
        for (int k = FLUX - 1; k >= 0; k--) begin
            scan_idx = TAG_WIDTH'((int'(rr_ptr_q) + k) % FLUX);
            if (!ext_size_empty_i[scan_idx]) begin
                grant_vld = 1'b1;
                grant     = scan_idx;
            end
        end
    end

    assign diff       = chroma_mode_i[grant] ? CHROMA_D : LUMA_D;
    assign short_size = ext_size < diff;
    assign real_size  = short_size ? '0 : ext_size - diff;

    always_comb begin
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_size_d  = out_size_q;
        rr_ptr_d    = rr_ptr_q;
        underflow_d = underflow_q;
        if (grant_vld && accept) begin
            out_valid_d = 1'b1;
            out_tag_d   = grant;
            out_size_d  = real_size;
            rr_ptr_d    = (grant == LAST_IDX) ? '0 : grant + TAG_WIDTH'(1);
            if (short_size) begin
                underflow_d[grant] = 1'b1;
            end
        end else if (real_size_write_o) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_size_q  <= '0;
            rr_ptr_q    <= '0;
            underflow_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_size_q  <= out_size_d;
            rr_ptr_q    <= rr_ptr_d;
            underflow_q <= underflow_d;
        end
    end

    // Pop is gated by reset so nothing is consumed while the block is held in reset.
    always_comb begin
        ext_size_read_o = '0;
        if (grant_vld && accept && !rst_i) begin
            ext_size_read_o[grant] = 1'b1;
        end
    end

    assign real_size_write_o = out_valid_q & ~real_size_full_i;
    assign real_size_din_o   = out_valid_q ? {out_tag_q, out_size_q} : '0;
    assign underflow_o       = underflow_q;

endmodule

// File: tb/tb_derive_real_size_multitap.sv
// Directed bench for derive_real_size_multitap: a FLUX=2 instance for the main scenarios
// and a FLUX=1 instance for the single-flux build.
module tb_derive_real_size_multitap;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [1:0] mode  = 2'b00;
    logic [1:0] uf;
    logic [7:0] dout  = 8'd0;
    logic [1:0] empty = 2'b11;
    logic [1:0] rd;
    logic       full  = 1'b0;
    logic       wr;
    logic [7:0] din;

    logic       mode1  = 1'b0;
    logic       uf1;
    logic [7:0] dout1  = 8'd0;
    logic       empty1 = 1'b1;
    logic       rd1;
    logic       full1  = 1'b0;
    logic       wr1;
    logic [7:0] din1;

    int checks = 0;
    int errors = 0;

    derive_real_size_multitap #(.FLUX(2)) dut (
        .clk_i(clk), .rst_i(rst), .chroma_mode_i(mode), .underflow_o(uf),
        .ext_size_dout_i(dout), .ext_size_empty_i(empty), .ext_size_read_o(rd),
        .real_size_full_i(full), .real_size_write_o(wr), .real_size_din_o(din)
    );

    derive_real_size_multitap #(.FLUX(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .chroma_mode_i(mode1), .underflow_o(uf1),
        .ext_size_dout_i(dout1), .ext_size_empty_i(empty1), .ext_size_read_o(rd1),
        .real_size_full_i(full1), .real_size_write_o(wr1), .real_size_din_o(din1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge, then let comb outputs settle.
    task automatic cyc(input logic [1:0] e, input logic [7:0] d, input logic f);
        @(negedge clk);
        empty = e;
        dout  = d;
        full  = f;
        #1;
    endtask

    initial begin
        #1;
        chk("rst_write", wr, 0);
        chk("rst_din", din, 0);
        chk("rst_read", rd, 0);
        chk("rst_uf", uf, 0);
        @(negedge clk);
        rst = 1'b0;

        // T2 luma basic: 15 - 7 = 8
        cyc(2'b10, 8'd15, 0);
        chk("t2_read", rd, 2'b01);
        chk("t2_write_n", wr, 0);
        cyc(2'b11, 8'd0, 0);
        chk("t2_write", wr, 1);
        chk("t2_din", din, 8);
        chk("t2_read_idle", rd, 0);
        cyc(2'b11, 8'd0, 0);
        chk("t2_drain", wr, 0);
        chk("t2_din_zero", din, 0);

        // T4 chroma / underflow on flux1
        mode = 2'b10;
        cyc(2'b01, 8'd5, 0);
        chk("t4_read1", rd, 2'b10);
        cyc(2'b01, 8'd2, 0);
        chk("t4_din_a", din, {1'b1, 7'd2});
        chk("t4_read2", rd, 2'b10);
        chk("t4_uf_clear", uf, 2'b00);
        cyc(2'b11, 8'd0, 0);
        chk("t4_din_b", din, {1'b1, 7'd0});
        chk("t4_uf_set", uf, 2'b10);
        cyc(2'b11, 8'd0, 0);
        cyc(2'b11, 8'd0, 0);
        chk("t4_uf_sticky", uf, 2'b10);
        mode = 2'b00;

        // T1 async reset while a word is held
        cyc(2'b10, 8'd15, 0);
        cyc(2'b10, 8'd15, 1);
        chk("t1_held", din, 8);
        #1 rst = 1'b1;
        #1;
        chk("t1_write", wr, 0);
        chk("t1_din", din, 0);
        chk("t1_read", rd, 0);
        chk("t1_uf", uf, 0);
        @(negedge clk);
        rst = 1'b0;
        empty = 2'b11;
        full  = 1'b0;
        #1;
        chk("t1_dropped", wr, 0);

        // T3 fairness, both fluxes non-empty; dout follows the flux the bench expects granted
        cyc(2'b00, 8'd10, 0);
        chk("t3_rd0", rd, 2'b01);
        cyc(2'b00, 8'd20, 0);
        chk("t3_rd1", rd, 2'b10);
        chk("t3_din0", din, {1'b0, 7'd3});
        cyc(2'b00, 8'd11, 0);
        chk("t3_rd2", rd, 2'b01);
        chk("t3_din1", din, {1'b1, 7'd13});
        cyc(2'b00, 8'd21, 0);
        chk("t3_rd3", rd, 2'b10);
        chk("t3_din2", din, {1'b0, 7'd4});
        cyc(2'b00, 8'd12, 0);
        chk("t3_rd4", rd, 2'b01);
        chk("t3_din3", din, {1'b1, 7'd14});
        cyc(2'b00, 8'd22, 0);
        chk("t3_rd5", rd, 2'b10);
        chk("t3_din4", din, {1'b0, 7'd5});
        chk("t3_wr4", wr, 1);
        cyc(2'b11, 8'd0, 0);
        chk("t3_din5", din, {1'b1, 7'd15});
        cyc(2'b11, 8'd0, 0);
        chk("t3_end", wr, 0);

        // T5 backpressure
        cyc(2'b10, 8'd15, 0);
        chk("t5_pop", rd, 2'b01);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b10, 8'd12, 1);
            chk("t5_hold_din", din, 8);
            chk("t5_hold_wr", wr, 0);
            chk("t5_hold_rd", rd, 0);
        end
        cyc(2'b10, 8'd12, 0);
        chk("t5_release_wr", wr, 1);
        chk("t5_release_din", din, 8);
        chk("t5_release_rd", rd, 2'b01);
        cyc(2'b11, 8'd0, 0);
        chk("t5_next_din", din, 5);
        cyc(2'b11, 8'd0, 0);
        chk("t5_end", wr, 0);

        // T6 boundaries: ext == LUMA_DIFF, ext max, upper dout bits ignored
        cyc(2'b10, 8'd7, 0);
        cyc(2'b10, 8'd127, 0);
        chk("t6_zero_wr", wr, 1);
        chk("t6_zero_din", din, 0);
        chk("t6_no_uf", uf, 2'b00);
        cyc(2'b10, 8'h8F, 0);
        chk("t6_max", din, 120);
        cyc(2'b11, 8'd0, 0);
        chk("t6_tagbits_ignored", din, 8);
        chk("t6_uf_final", uf, 2'b00);

        // FLUX=1 build, T2 scenario
        @(negedge clk);
        empty1 = 1'b0;
        dout1  = 8'd15;
        #1;
        chk("f1_read", rd1, 1);
        chk("f1_write_n", wr1, 0);
        @(negedge clk);
        empty1 = 1'b1;
        #1;
        chk("f1_write", wr1, 1);
        chk("f1_din", din1, 8);
        @(negedge clk);
        #1;
        chk("f1_drain", wr1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
